// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared word width, FSM states and index sizing for the wide adder
package wide_add_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int idx_width(input int nwords);
      return (nwords <= 1) ? 1 : $clog2(nwords);
   endfunction

endpackage

// File: rtl/carry_bypass_adder16.sv
// rtl/carry_bypass_adder16.sv - 16-bit adder slice built from four 4-bit carry-bypass blocks
module carry_bypass_adder16
   import wide_add_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   always_comb begin : bypass_chain
      logic [4:0] blk_c;
      logic [3:0] p;
      logic       c;
      blk_c    = '0;
      blk_c[0] = cin;
      sum      = '0;
      p        = '0;
      c        = 1'b0;
      for (int k = 0; k < 4; k++) begin
         c = blk_c[k];
         for (int i = 0; i < 4; i++) begin
            p[i]           = a[4*k+i] ^ b[4*k+i];
            sum[4*k+i]     = p[i] ^ c;
            c              = (a[4*k+i] & b[4*k+i]) | (p[i] & c);
         end
         // A fully propagating block forwards its carry-in directly past the ripple chain.
         blk_c[k+1] = (&p) ? blk_c[k] : c;
      end
      cout = blk_c[4];
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - streams a 16*NWORDS-bit add through one 16-bit slice, LSW first
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int NWORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_W*NWORDS-1:0] in_a,
   input  logic [WORD_W*NWORDS-1:0] in_b,
   input  logic                     in_cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_W*NWORDS-1:0] out_sum,
   output logic                     out_cout,
   output logic                     busy
);

   localparam int IW = idx_width(NWORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

   state_t state, state_nxt;

   logic [NWORDS-1:0][WORD_W-1:0] a_q, b_q, sum_q;
   logic                          carry_q;
   logic [IW-1:0]                 idx;

   logic [WORD_W-1:0] slice_sum;
   logic              slice_cout;
   logic              accept;
   logic              last_word;

   assign accept    = in_valid && in_ready;
   assign last_word = (idx == LAST_IDX);
   assign out_sum   = sum_q;

   carry_bypass_adder16 u_slice (
      .a    (a_q[idx]),
      .b    (b_q[idx]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_word) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode state only, so no input reaches them combinationally.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         idx      <= '0;
         out_cout <= 1'b0;
      end else if (accept) begin
         a_q     <= in_a;
         b_q     <= in_b;
         carry_q <= in_cin;
         idx     <= '0;
      end else if (state == RUN) begin
         sum_q[idx] <= slice_sum;
         carry_q    <= slice_cout;
         if (last_word) begin
            out_cout <= slice_cout;
            idx      <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer (NWORDS=4 and NWORDS=1)
module tb_wide_add_sequencer;

   localparam int W4 = 64;
   localparam int W1 = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
   logic [W4-1:0] in_a4 = '0, in_b4 = '0, out_sum4;
   logic          out_valid4, out_ready4 = 1'b0, out_cout4, busy4;

   logic          in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
   logic [W1-1:0] in_a1 = '0, in_b1 = '0, out_sum1;
   logic          out_valid1, out_ready1 = 1'b0, out_cout1, busy1;

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wide_add_sequencer #(.NWORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
   );

   wide_add_sequencer #(.NWORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
   );

   function automatic logic [W4:0] ref4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + 65'(c);
   endfunction

   function automatic logic [W1:0] ref1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + 17'(c);
   endfunction

   function automatic logic [W4-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive_op4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c,
                            output logic [W4:0] res, output int lat, output bit tmo);
      in_a4 = a; in_b4 = b; in_cin4 = c; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      tmo = !out_valid4;
      res = {out_cout4, out_sum4};
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   task automatic drive_op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic c,
                            output logic [W1:0] res, output int lat, output bit tmo);
      in_a1 = a; in_b1 = b; in_cin1 = c; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      tmo = !out_valid1;
      res = {out_cout1, out_sum1};
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk); @(posedge clk); #1;
      checks++; if (in_ready4 !== 1'b1) $display("FAIL rst_in_ready4 got %b exp 1", in_ready4); else passed++;
      checks++; if (out_valid4 !== 1'b0) $display("FAIL rst_out_valid4 got %b exp 0", out_valid4); else passed++;
      checks++; if (busy4 !== 1'b0) $display("FAIL rst_busy4 got %b exp 0", busy4); else passed++;
      checks++; if ({out_cout4, out_sum4} !== 65'd0) $display("FAIL rst_result4 got %h exp 0", {out_cout4, out_sum4}); else passed++;
      checks++; if ({in_ready1, out_valid1, busy1, out_cout1, out_sum1} !== {3'b100, 17'd0})
         $display("FAIL rst_dut1 got %h exp %h", {in_ready1, out_valid1, busy1, out_cout1, out_sum1}, {3'b100, 17'd0});
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) $display("FAIL rst_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready4, out_valid4); else passed++;
   endtask

   task automatic test_directed();
      logic [W4:0] res;
      int lat;
      bit tmo;
      drive_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, res, lat, tmo);
      checks++; if (tmo) $display("FAIL dir1_timeout got no out_valid exp out_valid"); else passed++;
      checks++; if (res !== ref4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0)) $display("FAIL dir1_result got %h exp %h", res, ref4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0)); else passed++;
      checks++; if (res !== {1'b1, 64'h0}) $display("FAIL dir1_const got %h exp %h", res, {1'b1, 64'h0}); else passed++;
      checks++; if (lat !== 4) $display("FAIL dir1_latency got %0d exp 4", lat); else passed++;
      drive_op4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, res, lat, tmo);
      checks++; if (res !== {1'b0, 64'h2222_2222_2222_2212}) $display("FAIL dir2_result got %h exp %h", res, {1'b0, 64'h2222_2222_2222_2212}); else passed++;
      // RUN phase should show busy with the input side closed.
      in_a4 = rand64(); in_b4 = rand64(); in_cin4 = 1'b0; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      checks++; if (busy4 !== 1'b1 || in_ready4 !== 1'b0 || out_valid4 !== 1'b0)
         $display("FAIL run_flags got busy=%b rdy=%b vld=%b exp 1 0 0", busy4, in_ready4, out_valid4);
      else passed++;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (out_valid4 !== 1'b1) $display("FAIL run_done got %b exp 1", out_valid4); else passed++;
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   task automatic test_hold();
      logic [W4-1:0] a, b;
      logic [W4:0]   held;
      int            n;
      a = rand64(); b = rand64();
      in_a4 = a; in_b4 = b; in_cin4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 40) begin @(posedge clk); #1; n++; end
      checks++; if (!out_valid4) $display("FAIL hold_timeout got no out_valid exp out_valid"); else passed++;
      held = {out_cout4, out_sum4};
      checks++; if (held !== ref4(a, b, 1'b1)) $display("FAIL hold_result got %h exp %h", held, ref4(a, b, 1'b1)); else passed++;
      for (int i = 0; i < 10; i++) begin
         in_valid4 = i[0];
         in_a4 = rand64(); in_b4 = rand64();
         @(posedge clk); #1;
         checks++;
         if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || {out_cout4, out_sum4} !== held)
            $display("FAIL hold_cycle%0d got vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=%h", i, out_valid4, in_ready4, {out_cout4, out_sum4}, held);
         else passed++;
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0)
         $display("FAIL hold_release got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid4, in_ready4, busy4);
      else passed++;
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) $display("FAIL idle_ready_noeffect got rdy=%b vld=%b exp 1 0", in_ready4, out_valid4); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [W4-1:0] a, b;
      logic          c;
      logic [W4:0]   exp_q[$];
      logic [W4:0]   exp;
      int            acc, prev_acc, n;
      prev_acc = -1;
      out_ready4 = 1'b1;
      in_valid4 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         while (!in_ready4 && n < 20) begin @(posedge clk); #1; n++; end
         a = rand64(); b = rand64(); c = 1'($urandom());
         in_a4 = a; in_b4 = b; in_cin4 = c;
         exp_q.push_back(ref4(a, b, c));
         @(posedge clk); #1;
         acc = cyc;
         if (prev_acc >= 0) begin
            checks++; if (acc - prev_acc !== 6) $display("FAIL b2b_interval%0d got %0d exp 6", k, acc - prev_acc); else passed++;
         end
         prev_acc = acc;
         n = 0;
         while (!out_valid4 && n < 40) begin @(posedge clk); #1; n++; end
         exp = exp_q.pop_front();
         checks++;
         if (!out_valid4 || {out_cout4, out_sum4} !== exp)
            $display("FAIL b2b_result%0d got vld=%b res=%h exp vld=1 res=%h", k, out_valid4, {out_cout4, out_sum4}, exp);
         else passed++;
      end
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W4-1:0] a, b;
      logic [W4:0]   res;
      int            lat;
      bit            tmo;
      in_a4 = rand64(); in_b4 = rand64(); in_cin4 = 1'b1; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (busy4 !== 1'b1) $display("FAIL midrun_busy got %b exp 1", busy4); else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid4 !== 1'b0 || out_sum4 !== 64'd0 || out_cout4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0)
         $display("FAIL midrun_reset got vld=%b sum=%h cout=%b rdy=%b busy=%b exp 0 0 0 1 0", out_valid4, out_sum4, out_cout4, in_ready4, busy4);
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      a = rand64(); b = rand64();
      drive_op4(a, b, 1'b0, res, lat, tmo);
      checks++; if (tmo || res !== ref4(a, b, 1'b0) || lat !== 4)
         $display("FAIL post_reset_op got res=%h lat=%0d exp res=%h lat=4", res, lat, ref4(a, b, 1'b0));
      else passed++;
   endtask

   task automatic test_nwords1();
      logic [W1-1:0] a, b;
      logic          c;
      logic [W1:0]   res;
      int            lat;
      bit            tmo;
      drive_op1(16'hFFFF, 16'hFFFF, 1'b1, res, lat, tmo);
      checks++; if (tmo || res !== {1'b1, 16'hFFFF}) $display("FAIL n1_directed got %h exp %h", res, {1'b1, 16'hFFFF}); else passed++;
      checks++; if (lat !== 1) $display("FAIL n1_latency got %0d exp 1", lat); else passed++;
      for (int i = 0; i < 10000; i++) begin
         a = 16'($urandom()); b = 16'($urandom()); c = 1'($urandom());
         drive_op1(a, b, c, res, lat, tmo);
         checks++;
         if (tmo || res !== ref1(a, b, c))
            $display("FAIL n1_random%0d got %h exp %h (a=%h b=%h cin=%b)", i, res, ref1(a, b, c), a, b, c);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_reset_mid_run();
      test_nwords1();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
